axis_corr_peak: RTL and testbench
=================================

# axis_corr_peak

Windowed peak detector for the correlator output stream. It consumes beats of NUM_PARALLEL signed correlation lanes and tracks the largest-magnitude sample, with its sample index, over a fixed window of WINDOW_LEN beats. At each window end it emits one {index, magnitude} beat if the peak meets a runtime threshold. It sits directly downstream of the bit correlator and feeds the timing/acquisition logic.

## Interface
- NUM_PARALLEL, 8: lanes per input beat; power of two.
- FILT_WIDTH, 16: signed width of each lane.
- WINDOW_LEN, 1024: beats per window; power of two, ≥2.
- INDEX_WIDTH, log2(WINDOW_LEN*NUM_PARALLEL) (localparam): sample index width within a window.
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- threshold  in  FILT_WIDTH  unsigned peak threshold; sampled on the first beat of each window.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  NUM_PARALLEL*FILT_WIDTH  lane n at bits [n*FILT_WIDTH +: FILT_WIDTH]; lane 0 is the earliest sample.
- m_axis_tvalid  out  1  peak report valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  INDEX_WIDTH+FILT_WIDTH  {index, magnitude}; magnitude in the low FILT_WIDTH bits.

## Operation
- Global pipeline enable: ena = ~(m_axis_tvalid & ~m_axis_tready). s_axis_tready = ena, forced 0 while rst_n is low.
- Stage 1, on ena: register a metric per lane plus a valid bit (accepted beat). Lanes with metric < 0 are treated as 0.
- Stage 2, on ena: a reduction tree picks the max metric and its lane number, registered with a valid bit. On a tie, the lower lane wins.
- Stage 3 is the window tracker FSM, advancing on ena with stage-2 valid.
  - FIRST: load peak = max, index = 0*NUM_PARALLEL + lane, and latch threshold. Beat counter becomes 1. Go to TRACK.
  - TRACK: if max > peak (strictly greater, so the earlier sample wins ties), load peak and index = beat*NUM_PARALLEL + lane. Increment the beat counter.
  - On the beat where the counter is WINDOW_LEN-1, after the update, close the window and return to FIRST. The counter wraps to 0.
- Window close: if the final peak ≥ the latched threshold, load the output register and assert m_axis_tvalid. Otherwise report nothing.
- Output register: holds until m_axis_tvalid & m_axis_tready. While stalled, ena = 0 freezes all stages, including the in-flight valid bits, and no data is lost.
- Arithmetic: the metric is FILT_WIDTH unsigned. INDEX_WIDTH = log2(WINDOW_LEN)+log2(NUM_PARALLEL), and the index never wraps within a window.
- Reset (asynchronous, any time):
  - FSM = FIRST, counter = 0, peak = 0, all valid bits = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0.
  - A window in progress is discarded. The first accepted beat after release starts a new window.

## Timing
- Latency is 3 clk from acceptance of a window's last input beat to m_axis_tvalid high, with no stall.
- Throughput is one input beat per clk when m_axis_tready is held high. A report and a window close on the same cycle is impossible to stall, because the output register is always free when ena = 1.
- Simultaneous output handshake and new window close: the output register reloads on the same edge and m_axis_tvalid stays high.
- s_axis_tready is combinational from m_axis_tvalid and m_axis_tready only.
- Input bubbles (s_axis_tvalid = 0) do not advance the beat counter.

## Configuration
- CORR_PEAK_ABS_EN defined: metric = |x|. The most-negative value −2^(FILT_WIDTH−1) saturates to 2^(FILT_WIDTH−1)−1. Strong negative correlations are reported as peaks.
- Not defined: metric = x when x ≥ 0, else 0. Only positive correlation peaks are reported.

## Test plan
All scenarios use NUM_PARALLEL=8, FILT_WIDTH=16, WINDOW_LEN=4, threshold=100, CORR_PEAK_ABS_EN defined unless noted.
- Single peak: all lanes 0 except beat 2 lane 5 = 300, m_axis_tready=1 → one report {index=21, mag=300}, 3 clk after beat 3 is accepted.
- Below threshold: window max 99 → no m_axis_tvalid. The next window, with max 100 at beat 0 lane 0, reports {0, 100}.
- Tie and sign:
  - beat 1 lane 3 = −500 and beat 3 lane 0 = 500 → {11, 500}.
  - Same stimulus with the macro undefined → {24, 500}.
  - −32768 with the macro defined → mag 32767.
- Backpressure: hold m_axis_tready=0 across two windows each containing a peak → s_axis_tready drops while the report is pending. After release, both reports arrive in order with correct values and no input beat is lost.
- Bubbles: random s_axis_tvalid gaps within a window → same report as gap-free stimulus.
- Reset mid-window: assert rst_n low after beat 1 (peak 400 seen) → m_axis_tvalid=0 immediately. The next 4 beats, with max 150 at beat 0 lane 1, report {1, 150}.

Source files
------------

// File: rtl/axis_corr_peak.sv
// axis_corr_peak: windowed peak detector for the correlator output stream.
// Three-stage pipeline: per-lane metric, max/lane reduction, window tracker.
// At each window close a {index, magnitude} report is emitted if the peak
// reaches the threshold latched on the first beat of that window.
// Optional build macro CORR_PEAK_ABS_EN: metric = |x| (saturating) instead of
// max(x, 0).
module axis_corr_peak #(
  parameter int NUM_PARALLEL = 8,
  parameter int FILT_WIDTH   = 16,
  parameter int WINDOW_LEN   = 1024,
  localparam int INDEX_WIDTH = $clog2(WINDOW_LEN * NUM_PARALLEL)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [FILT_WIDTH-1:0]                threshold,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [NUM_PARALLEL*FILT_WIDTH-1:0]   s_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [INDEX_WIDTH+FILT_WIDTH-1:0]    m_axis_tdata
);

  localparam int LANE_W = $clog2(NUM_PARALLEL);
  localparam int BEAT_W = $clog2(WINDOW_LEN);
  localparam int DATA_W = NUM_PARALLEL * FILT_WIDTH;
  localparam int OUT_W  = INDEX_WIDTH + FILT_WIDTH;

  localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(WINDOW_LEN - 1);
  localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0]     BEAT_ZERO = BEAT_W'(0);
  localparam logic [FILT_WIDTH-1:0] MAG_ZERO  = FILT_WIDTH'(0);

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Per-lane metric: negative samples clamp to zero, or fold to magnitude.
  function automatic logic [FILT_WIDTH-1:0] lane_metric(input logic [FILT_WIDTH-1:0] x);
    logic [FILT_WIDTH-1:0] m;
`ifdef CORR_PEAK_ABS_EN
    if (x == {1'b1, {(FILT_WIDTH-1){1'b0}}}) begin
      m = {1'b0, {(FILT_WIDTH-1){1'b1}}};
    end else if (x[FILT_WIDTH-1]) begin
      m = ~x + {{(FILT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = x;
    end
`else
    if (x[FILT_WIDTH-1]) begin
      m = MAG_ZERO;
    end else begin
      m = x;
    end
`endif
    return m;
  endfunction

  // Binary max tree over the lanes; the left (lower-lane) child wins ties.
  function automatic logic [LANE_W+FILT_WIDTH-1:0] max_tree(input logic [DATA_W-1:0] metrics);
    logic [FILT_WIDTH-1:0] mag  [2*NUM_PARALLEL];
    logic [LANE_W-1:0]     lane [2*NUM_PARALLEL];
    for (int i = 0; i < 2*NUM_PARALLEL; i++) begin
      mag[i]  = MAG_ZERO;
      lane[i] = LANE_W'(0);
    end
    for (int i = 0; i < NUM_PARALLEL; i++) begin
      mag[NUM_PARALLEL+i]  = metrics[i*FILT_WIDTH +: FILT_WIDTH];
      lane[NUM_PARALLEL+i] = LANE_W'(i);
    end
    for (int i = NUM_PARALLEL-1; i >= 1; i--) begin
      if (mag[2*i+1] > mag[2*i]) begin
        mag[i]  = mag[2*i+1];
        lane[i] = lane[2*i+1];
      end else begin
        mag[i]  = mag[2*i];
        lane[i] = lane[2*i];
      end
    end
    return {lane[1], mag[1]};
  endfunction

  logic                          ena_s;
  logic                          s1_valid_r;
  logic [DATA_W-1:0]             s1_metric_r;
  logic [LANE_W+FILT_WIDTH-1:0]  tree_s;
  logic                          s2_valid_r;
  logic [FILT_WIDTH-1:0]         s2_max_r;
  logic [LANE_W-1:0]             s2_lane_r;
  state_t                        state_r;
  state_t                        state_nxt_s;
  logic                          advance_s;
  logic                          last_beat_s;
  logic                          load_s;
  logic                          close_s;
  logic [BEAT_W-1:0]             beat_cnt_r;
  logic [FILT_WIDTH-1:0]         peak_r;
  logic [INDEX_WIDTH-1:0]        index_r;
  logic [FILT_WIDTH-1:0]         thr_r;
  logic [FILT_WIDTH-1:0]         new_peak_s;
  logic [INDEX_WIDTH-1:0]        new_idx_s;
  logic                          report_s;
  logic                          out_valid_r;
  logic [OUT_W-1:0]              out_data_r;

  // The whole pipeline stalls only while a report waits on the downstream.
  assign ena_s         = ~(out_valid_r & ~m_axis_tready);
  assign s_axis_tready = ena_s & rst_n;
  assign m_axis_tvalid = out_valid_r;
  assign m_axis_tdata  = out_data_r;

  // Stage 1: register per-lane metrics and the accepted-beat flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_metric_r <= {DATA_W{1'b0}};
    end else if (ena_s) begin
      s1_valid_r <= s_axis_tvalid;
      for (int i = 0; i < NUM_PARALLEL; i++) begin
        s1_metric_r[i*FILT_WIDTH +: FILT_WIDTH] <= lane_metric(s_axis_tdata[i*FILT_WIDTH +: FILT_WIDTH]);
      end
    end
  end

  assign tree_s = max_tree(s1_metric_r);

  // Stage 2: register the beat maximum and its lane number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_max_r   <= MAG_ZERO;
      s2_lane_r  <= LANE_W'(0);
    end else if (ena_s) begin
      s2_valid_r <= s1_valid_r;
      s2_max_r   <= tree_s[FILT_WIDTH-1:0];
      s2_lane_r  <= tree_s[LANE_W+FILT_WIDTH-1:FILT_WIDTH];
    end
  end

  assign advance_s   = ena_s & s2_valid_r;
  assign last_beat_s = (beat_cnt_r == BEAT_LAST);

  // Window tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FIRST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Window tracker next-state: leave FIRST on any beat, close on the last.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FIRST: begin
        if (advance_s) begin
          state_nxt_s = ST_TRACK;
        end else begin
          state_nxt_s = ST_FIRST;
        end
      end
      ST_TRACK: begin
        if (advance_s && last_beat_s) begin
          state_nxt_s = ST_FIRST;
        end else begin
          state_nxt_s = ST_TRACK;
        end
      end
      default: state_nxt_s = ST_FIRST;
    endcase
  end

  // Window tracker outputs: first beat always loads, later beats load only
  // on a strictly larger value so the earlier sample keeps a tie.
  always_comb begin
    load_s  = 1'b0;
    close_s = 1'b0;
    case (state_r)
      ST_FIRST: begin
        load_s  = advance_s;
        close_s = 1'b0;
      end
      ST_TRACK: begin
        load_s  = advance_s & (s2_max_r > peak_r);
        close_s = advance_s & last_beat_s;
      end
      default: begin
        load_s  = 1'b0;
        close_s = 1'b0;
      end
    endcase
  end

  // Candidate peak after this beat's update; the counter is zero in FIRST.
  always_comb begin
    new_peak_s = peak_r;
    new_idx_s  = index_r;
    if (load_s) begin
      new_peak_s = s2_max_r;
      new_idx_s  = {beat_cnt_r, s2_lane_r};
    end else begin
      new_peak_s = peak_r;
      new_idx_s  = index_r;
    end
  end

  assign report_s = close_s & (new_peak_s >= thr_r);

  // Window datapath: peak, index, beat counter and latched threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_r     <= MAG_ZERO;
      index_r    <= INDEX_WIDTH'(0);
      beat_cnt_r <= BEAT_ZERO;
      thr_r      <= MAG_ZERO;
    end else if (advance_s) begin
      peak_r  <= new_peak_s;
      index_r <= new_idx_s;
      if (last_beat_s) begin
        beat_cnt_r <= BEAT_ZERO;
      end else begin
        beat_cnt_r <= beat_cnt_r + BEAT_ONE;
      end
      if (state_r == ST_FIRST) begin
        thr_r <= threshold;
      end
    end
  end

  // Output register: a new report may reload on the same edge as a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
    end else if (report_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= {new_idx_s, new_peak_s};
    end else if (out_valid_r && m_axis_tready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_corr_peak.sv
// Self-checking bench for axis_corr_peak (NUM_PARALLEL=8, FILT_WIDTH=16,
// WINDOW_LEN=4). A sample-level reference model scans each window in sample
// order and queues the expected reports; directed windows pin literal values.
module tb_axis_corr_peak;
  localparam int NP = 8;
  localparam int FW = 16;
  localparam int WL = 4;
  localparam int IW = $clog2(WL * NP);
  localparam int DW = NP * FW;
  localparam int OW = IW + FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] threshold = 16'd100;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [OW-1:0] m_tdata;

  int checks = 0;
  int errors = 0;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] rx_q[$];
  int mdl_beat = 0;
  int mdl_best = 0;
  int mdl_idx  = 0;
  int mdl_thr  = 0;

  logic [DW-1:0] win_buf [WL];
  logic [DW-1:0] win_keep [WL];
  bit rnd_on = 1'b0;

  always #5 clk = ~clk;

  axis_corr_peak #(.NUM_PARALLEL(NP), .FILT_WIDTH(FW), .WINDOW_LEN(WL)) dut (
    .clk(clk), .rst_n(rst_n), .threshold(threshold),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int metric_of(input logic [FW-1:0] raw);
    int x;
    int m;
    x = int'($signed(raw));
`ifdef CORR_PEAK_ABS_EN
    m = (x < 0) ? -x : x;
    if (m > (1 << (FW-1)) - 1) m = (1 << (FW-1)) - 1;
`else
    m = (x < 0) ? 0 : x;
`endif
    return m;
  endfunction

  // Reference: scan the window sample by sample; earliest sample keeps ties.
  function automatic void model_accept(input logic [DW-1:0] d);
    int m;
    if (mdl_beat == 0) begin
      mdl_thr  = int'(threshold);
      mdl_best = -1;
    end
    for (int l = 0; l < NP; l++) begin
      m = metric_of(d[l*FW +: FW]);
      if (m > mdl_best) begin
        mdl_best = m;
        mdl_idx  = mdl_beat * NP + l;
      end
    end
    mdl_beat++;
    if (mdl_beat == WL) begin
      if (mdl_best >= mdl_thr) exp_q.push_back({IW'(mdl_idx), FW'(mdl_best)});
      mdl_beat = 0;
    end
  endfunction

  // Compare outputs against the model, then feed accepted beats to it.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_beat = 0;
    end else begin
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_report actual=0x%0h required=none", m_tdata);
        end else begin
          check("report_vs_model", m_tdata, exp_q[0]);
          if (m_tready) void'(exp_q.pop_front());
        end
        if (m_tready) rx_q.push_back(m_tdata);
      end
      if (s_tvalid && s_tready) model_accept(s_tdata);
    end
  end

  task automatic send_beat(input logic [DW-1:0] d);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    do begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 2000);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout actual=0 required=1");
    end
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_win(input int gap_max);
    for (int b = 0; b < WL; b++) begin
      send_beat(win_buf[b]);
      if (gap_max > 0 && b < WL-1) idle($urandom_range(gap_max, 0));
    end
  endtask

  task automatic clear_win();
    for (int b = 0; b < WL; b++) win_buf[b] = '0;
  endtask

  task automatic set_lane(input int b, input int l, input int v);
    win_buf[b][l*FW +: FW] = FW'(v);
  endtask

  task automatic wait_report(output int cyc);
    cyc = 1;
    while (!m_tvalid && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int rx0;
    int amp;
    int v;

    // Reset state
    #12;
    check("reset_m_tvalid", m_tvalid, 1'b0);
    check("reset_m_tdata", m_tdata, '0);
    check("reset_s_tready", s_tready, 1'b0);
    rst_n = 1'b1;
    idle(1);
    check("post_reset_s_tready", s_tready, 1'b1);

    // Single peak at beat 2 lane 5
    clear_win();
    set_lane(2, 5, 300);
    send_win(0);
    check("model_single_peak", (exp_q.size() > 0) ? exp_q[$] : '0, {5'd21, 16'd300});
    wait_report(cyc);
    check("latency", cyc, 3);
    check("single_peak", m_tdata, {5'd21, 16'd300});
    idle(3);

    // Below threshold, then exactly at threshold
    rx0 = rx_q.size();
    clear_win();
    set_lane(1, 2, 99);
    send_win(0);
    idle(6);
    check("below_thr_no_report", rx_q.size() - rx0, 0);
    clear_win();
    set_lane(0, 0, 100);
    send_win(0);
    wait_report(cyc);
    check("at_threshold", m_tdata, {5'd0, 16'd100});
    idle(3);

    // Tie and sign
    clear_win();
    set_lane(1, 3, -500);
    set_lane(3, 0, 500);
    send_win(0);
    wait_report(cyc);
`ifdef CORR_PEAK_ABS_EN
    check("tie_sign", m_tdata, {5'd11, 16'd500});
`else
    check("tie_sign", m_tdata, {5'd24, 16'd500});
`endif
    idle(3);

    // Most-negative input
    rx0 = rx_q.size();
    clear_win();
    set_lane(0, 7, -32768);
    send_win(0);
    idle(6);
`ifdef CORR_PEAK_ABS_EN
    check("most_negative_count", rx_q.size() - rx0, 1);
    check("most_negative", (rx_q.size() > 0) ? rx_q[$] : '0, {5'd7, 16'd32767});
`else
    check("most_negative_count", rx_q.size() - rx0, 0);
`endif

    // Backpressure across two windows
    rx0 = rx_q.size();
    m_tready = 1'b0;
    fork
      begin
        clear_win();
        set_lane(1, 4, 200);
        send_win(0);
        clear_win();
        set_lane(2, 6, 300);
        send_win(0);
      end
      begin
        idle(20);
        check("bp_s_tready_low", s_tready, 1'b0);
        check("bp_m_tvalid_held", m_tvalid, 1'b1);
        check("bp_data_held", m_tdata, {5'd12, 16'd200});
        m_tready = 1'b1;
      end
    join
    idle(8);
    check("bp_count", rx_q.size() - rx0, 2);
    if (rx_q.size() >= 2) begin
      check("bp_first", rx_q[rx_q.size()-2], {5'd12, 16'd200});
      check("bp_second", rx_q[rx_q.size()-1], {5'd22, 16'd300});
    end

    // Bubbles: same window gap-free and with random gaps
    rx0 = rx_q.size();
    for (int b = 0; b < WL; b++)
      for (int l = 0; l < NP; l++) begin
        v = int'($urandom_range(2000, 0)) - 1000;
        win_keep[b][l*FW +: FW] = FW'(v);
      end
    win_keep[$urandom_range(WL-1, 0)][$urandom_range(NP-1, 0) * FW +: FW] = 16'd1500;
    for (int b = 0; b < WL; b++) win_buf[b] = win_keep[b];
    send_win(0);
    idle(2);
    send_win(3);
    idle(6);
    check("bubble_count", rx_q.size() - rx0, 2);
    if (rx_q.size() >= 2) check("bubble_same", rx_q[rx_q.size()-1], rx_q[rx_q.size()-2]);

    // Reset while a report is pending
    rx0 = rx_q.size();
    m_tready = 1'b0;
    clear_win();
    set_lane(1, 2, 400);
    send_win(0);
    wait_report(cyc);
    check("pending_before_reset", m_tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("pending_reset_tvalid", m_tvalid, 1'b0);
    check("pending_reset_tdata", m_tdata, '0);
    idle(2);
    m_tready = 1'b1;
    #2 rst_n = 1'b1;
    idle(1);

    // Reset mid-window after the 400 beat
    clear_win();
    set_lane(1, 2, 400);
    send_beat(win_buf[0]);
    send_beat(win_buf[1]);
    #2 rst_n = 1'b0;
    #1;
    check("midwin_reset_tvalid", m_tvalid, 1'b0);
    check("midwin_reset_s_tready", s_tready, 1'b0);
    idle(2);
    #2 rst_n = 1'b1;
    idle(1);
    clear_win();
    set_lane(0, 1, 150);
    send_win(0);
    wait_report(cyc);
    check("after_reset_report", m_tdata, {5'd1, 16'd150});
    idle(4);
    check("reset_discard_count", rx_q.size() - rx0, 1);

    // Randomized windows with random backpressure and bubbles
    threshold = 16'd500;
    idle(2);
    rnd_on = 1'b1;
    fork
      begin
        for (int w = 0; w < 60; w++) begin
          case ($urandom_range(2, 0))
            0:       amp = 300;
            1:       amp = 700;
            default: amp = 20000;
          endcase
          for (int b = 0; b < WL; b++)
            for (int l = 0; l < NP; l++) begin
              v = int'($urandom_range(2 * amp, 0)) - amp;
              win_buf[b][l*FW +: FW] = FW'(v);
            end
          if ($urandom_range(7, 0) == 0)
            win_buf[$urandom_range(WL-1, 0)][$urandom_range(NP-1, 0) * FW +: FW] = 16'h8000;
          send_win($urandom_range(1, 0) * 2);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(3, 0) != 0);
        end
        m_tready = 1'b1;
      end
    join

    // Drain
    m_tready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      idle(1);
      cyc++;
    end
    idle(4);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
